// File: rtl/note_seq_pkg.sv
// Shared types and sizing for the note step sequencer.
package note_seq_pkg;

  localparam int unsigned STEPS   = 16;
  localparam int unsigned OSC_W   = 12;
  localparam int unsigned STEP_W  = $clog2(STEPS);
  localparam int unsigned TEMPO_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GATE = 2'd1,
    GAP  = 2'd2
  } seq_state_t;

  typedef struct packed {
    logic             rest;
    logic [OSC_W-1:0] count;
  } ram_entry_t;

  // A step needs at least one gate tick and one gap tick.
  function automatic logic [TEMPO_W-1:0] clamp_tempo(input logic [TEMPO_W-1:0] t);
    return (t < TEMPO_W'(2)) ? TEMPO_W'(2) : t;
  endfunction

  // Gate is kept below the step length so trig always drops before the next note.
  function automatic logic [TEMPO_W-1:0] clamp_gate(input logic [TEMPO_W-1:0] g,
                                                    input logic [TEMPO_W-1:0] t_eff);
    logic [TEMPO_W-1:0] g1;
    g1 = (g == '0) ? TEMPO_W'(1) : g;
    return (g1 > (t_eff - TEMPO_W'(1))) ? (t_eff - TEMPO_W'(1)) : g1;
  endfunction

endpackage

// File: rtl/seq_tick_gen.sv
// Step-timing prescaler: one-cycle tick every TICK_DIV clocks, restartable by i_clr.
module seq_tick_gen #(
  parameter int unsigned TICK_DIV = 2048
) (
  input  logic clk,
  input  logic rstn,
  input  logic i_clr,
  output logic o_tick_c
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_wrap;

  assign w_wrap   = (r_cnt == CNT_MAX);
  assign o_tick_c = w_wrap && !i_clr;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_cnt <= '0;
    end else if (i_clr || w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/note_sequencer.sv
// Pattern step sequencer presenting osc_count and a gated trig to the synth voice.
// Build option: SEQ_LOOP_EN makes the pattern repeat until stopped instead of ending.
module note_sequencer
  import note_seq_pkg::*;
#(
  parameter int unsigned TICK_DIV = 2048
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               start,
  input  logic               stop,
  input  logic               wr_en,
  input  logic [STEP_W-1:0]  wr_addr,
  input  logic [OSC_W-1:0]   wr_count,
  input  logic               wr_rest,
  input  logic [TEMPO_W-1:0] tempo,
  input  logic [TEMPO_W-1:0] gate_len,
  input  logic [STEP_W-1:0]  last_step,
  output logic               trig,
  output logic [OSC_W-1:0]   osc_count,
  output logic [STEP_W-1:0]  step,
  output logic               busy,
  output logic               done
);

  seq_state_t         r_state,     w_state_nxt;
  logic               r_trig,      w_trig_nxt;
  logic [OSC_W-1:0]   r_osc,       w_osc_nxt;
  logic [STEP_W-1:0]  r_step,      w_step_nxt;
  logic               r_busy,      w_busy_nxt;
  logic               r_done,      w_done_nxt;
  logic [STEP_W-1:0]  r_last,      w_last_nxt;
  logic [TEMPO_W-1:0] r_tempo_eff, w_tempo_eff_nxt;
  logic [TEMPO_W-1:0] r_gate_eff,  w_gate_eff_nxt;
  logic [TEMPO_W-1:0] r_tick_cnt,  w_tick_cnt_nxt;

  ram_entry_t         r_ram [STEPS];

  logic               w_start_go;
  logic               w_tick;
  logic               w_enter;
  logic [STEP_W-1:0]  w_rd_addr;
  ram_entry_t         w_rd;
  logic [TEMPO_W-1:0] w_tick_inc;
  logic [TEMPO_W-1:0] w_tempo_cl;

  assign trig      = r_trig;
  assign osc_count = r_osc;
  assign step      = r_step;
  assign busy      = r_busy;
  assign done      = r_done;

  assign w_start_go = start && !stop && (r_state == IDLE);
  assign w_tick_inc = r_tick_cnt + TEMPO_W'(1);
  assign w_tempo_cl = clamp_tempo(tempo);

  // Next entry is step+1 only when advancing mid-pattern; start and wrap both read step 0.
  assign w_rd_addr = ((r_state == GAP) && (r_step != r_last)) ? (r_step + STEP_W'(1)) : '0;
  assign w_rd      = r_ram[w_rd_addr];

  seq_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk      (clk),
    .rstn     (rstn),
    .i_clr    (w_start_go),
    .o_tick_c (w_tick)
  );

  // Pattern store is deliberately left out of reset so a loaded pattern survives it.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_ram[wr_addr] <= '{rest: wr_rest, count: wr_count};
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_state     <= IDLE;
      r_trig      <= 1'b0;
      r_osc       <= '0;
      r_step      <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_last      <= '0;
      r_tempo_eff <= TEMPO_W'(2);
      r_gate_eff  <= TEMPO_W'(1);
      r_tick_cnt  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_trig      <= w_trig_nxt;
      r_osc       <= w_osc_nxt;
      r_step      <= w_step_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_last      <= w_last_nxt;
      r_tempo_eff <= w_tempo_eff_nxt;
      r_gate_eff  <= w_gate_eff_nxt;
      r_tick_cnt  <= w_tick_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_trig_nxt      = r_trig;
    w_osc_nxt       = r_osc;
    w_step_nxt      = r_step;
    w_busy_nxt      = r_busy;
    w_done_nxt      = 1'b0;
    w_last_nxt      = r_last;
    w_tempo_eff_nxt = r_tempo_eff;
    w_gate_eff_nxt  = r_gate_eff;
    w_tick_cnt_nxt  = r_tick_cnt;
    w_enter         = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_start_go) begin
          w_enter     = 1'b1;
          w_last_nxt  = last_step;
          w_state_nxt = GATE;
          w_busy_nxt  = 1'b1;
        end
      end

      GATE: begin
        if (stop) begin
          w_trig_nxt  = 1'b0;
          w_busy_nxt  = 1'b0;
          w_state_nxt = IDLE;
        end else if (w_tick) begin
          w_tick_cnt_nxt = w_tick_inc;
          if (w_tick_inc == r_gate_eff) begin
            w_trig_nxt  = 1'b0;
            w_state_nxt = GAP;
          end
        end
      end

      GAP: begin
        if (stop) begin
          w_trig_nxt  = 1'b0;
          w_busy_nxt  = 1'b0;
          w_state_nxt = IDLE;
        end else if (w_tick) begin
          w_tick_cnt_nxt = w_tick_inc;
          if (w_tick_inc == r_tempo_eff) begin
            if (r_step == r_last) begin
`ifdef SEQ_LOOP_EN
              w_enter     = 1'b1;
              w_state_nxt = GATE;
`else
              w_state_nxt = IDLE;
              w_busy_nxt  = 1'b0;
              w_done_nxt  = 1'b1;
`endif
            end else begin
              w_enter     = 1'b1;
              w_state_nxt = GATE;
            end
          end
        end
      end

      default: begin
        w_state_nxt = IDLE;
        w_trig_nxt  = 1'b0;
        w_busy_nxt  = 1'b0;
      end
    endcase

    // Step entry: note, trig, step index and timing all update together.
    if (w_enter) begin
      w_step_nxt      = w_rd_addr;
      w_osc_nxt       = w_rd.count;
      w_trig_nxt      = !w_rd.rest;
      w_tick_cnt_nxt  = '0;
      w_tempo_eff_nxt = w_tempo_cl;
      w_gate_eff_nxt  = clamp_gate(gate_len, w_tempo_cl);
    end
  end

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer (TICK_DIV=4); honours SEQ_LOOP_EN like the design.
module tb_note_sequencer;
  import note_seq_pkg::*;

  localparam int unsigned TICK_DIV = 4;

  logic               clk = 1'b0;
  logic               rstn, start, stop, wr_en, wr_rest;
  logic [STEP_W-1:0]  wr_addr, last_step;
  logic [OSC_W-1:0]   wr_count;
  logic [TEMPO_W-1:0] tempo, gate_len;
  logic               trig, busy, done;
  logic [OSC_W-1:0]   osc_count;
  logic [STEP_W-1:0]  step;

  always #5 clk = ~clk;

  note_sequencer #(.TICK_DIV(TICK_DIV)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .stop      (stop),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_count  (wr_count),
    .wr_rest   (wr_rest),
    .tempo     (tempo),
    .gate_len  (gate_len),
    .last_step (last_step),
    .trig      (trig),
    .osc_count (osc_count),
    .step      (step),
    .busy      (busy),
    .done      (done)
  );

  typedef struct {
    int               k;
    logic             trig;
    logic [OSC_W-1:0] osc;
    logic [STEP_W-1:0] stp;
    logic             busy;
    logic             done;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;
  int   k_now  = 0;

  task automatic cyc();
    @(posedge clk);
    #1;
    k_now++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic void add(input int k, input logic t, input int osc, input int s,
                              input logic b, input logic d);
    vec_t v;
    v.k = k; v.trig = t; v.osc = OSC_W'(osc); v.stp = STEP_W'(s); v.busy = b; v.done = d;
    vecs.push_back(v);
  endfunction

  task automatic run_vecs(input string tag);
    foreach (vecs[i]) begin
      while (k_now < vecs[i].k) cyc();
      chk($sformatf("%s k=%0d trig", tag, vecs[i].k), 32'(trig), 32'(vecs[i].trig));
      chk($sformatf("%s k=%0d osc", tag, vecs[i].k), 32'(osc_count), 32'(vecs[i].osc));
      chk($sformatf("%s k=%0d step", tag, vecs[i].k), 32'(step), 32'(vecs[i].stp));
      chk($sformatf("%s k=%0d busy", tag, vecs[i].k), 32'(busy), 32'(vecs[i].busy));
      chk($sformatf("%s k=%0d done", tag, vecs[i].k), 32'(done), 32'(vecs[i].done));
    end
    vecs.delete();
  endtask

  task automatic write_step(input int a, input int cnt, input logic rest);
    wr_en = 1'b1; wr_addr = STEP_W'(a); wr_count = OSC_W'(cnt); wr_rest = rest;
    cyc();
    wr_en = 1'b0;
  endtask

  // k_now becomes 0 on the edge that samples start.
  task automatic do_start();
    start = 1'b1;
    k_now = -1;
    cyc();
    start = 1'b0;
  endtask

  task automatic go_idle(input string tag);
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    cyc();
    chk({tag, " idle busy"}, 32'(busy), 32'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic seen;
    rstn = 1'b0; start = 1'b0; stop = 1'b0; wr_en = 1'b0; wr_rest = 1'b0;
    wr_addr = '0; wr_count = '0; tempo = 16'd4; gate_len = 16'd2; last_step = STEP_W'(2);
    cyc(); cyc();
    rstn = 1'b1;
    chk("reset trig", 32'(trig), 32'(0));
    chk("reset osc", 32'(osc_count), 32'(0));
    chk("reset step", 32'(step), 32'(0));
    chk("reset busy", 32'(busy), 32'(0));
    chk("reset done", 32'(done), 32'(0));

    write_step(0, 100, 1'b0);
    write_step(1, 200, 1'b0);
    write_step(2, 300, 1'b0);

    // Basic: gate 2 ticks (8 clk), gap 2 ticks (8 clk) per step.
    do_start();
    add(0, 1, 100, 0, 1, 0);  add(7, 1, 100, 0, 1, 0);
    add(8, 0, 100, 0, 1, 0);  add(15, 0, 100, 0, 1, 0);
    add(16, 1, 200, 1, 1, 0); add(23, 1, 200, 1, 1, 0);
    add(24, 0, 200, 1, 1, 0); add(32, 1, 300, 2, 1, 0);
    add(40, 0, 300, 2, 1, 0); add(47, 0, 300, 2, 1, 0);
`ifdef SEQ_LOOP_EN
    add(48, 1, 100, 0, 1, 0);
`else
    add(48, 0, 300, 2, 0, 1); add(49, 0, 300, 2, 0, 0);
`endif
    run_vecs("basic");
    go_idle("basic");

    // Minimum clamp: tempo 0 -> 2 ticks, gate 0 -> 1 tick.
    tempo = 16'd0; gate_len = 16'd0; last_step = STEP_W'(0);
    do_start();
    add(0, 1, 100, 0, 1, 0); add(3, 1, 100, 0, 1, 0);
    add(4, 0, 100, 0, 1, 0); add(7, 0, 100, 0, 1, 0);
`ifdef SEQ_LOOP_EN
    add(8, 1, 100, 0, 1, 0);
`else
    add(8, 0, 100, 0, 0, 1); add(9, 0, 100, 0, 0, 0);
`endif
    run_vecs("clampmin");
    go_idle("clampmin");

    // Rest step and gate clamp: gate 9 with tempo 4 -> 3 ticks high, 1 low.
    write_step(1, 200, 1'b1);
    tempo = 16'd4; gate_len = 16'd9; last_step = STEP_W'(2);
    do_start();
    add(0, 1, 100, 0, 1, 0);  add(11, 1, 100, 0, 1, 0);
    add(12, 0, 100, 0, 1, 0); add(16, 0, 200, 1, 1, 0);
    add(31, 0, 200, 1, 1, 0); add(32, 1, 300, 2, 1, 0);
    add(43, 1, 300, 2, 1, 0); add(44, 0, 300, 2, 1, 0);
    run_vecs("rest");
    go_idle("rest");

    // Stop mid-GATE at step 1; a start while busy must be ignored.
    write_step(1, 200, 1'b0);
    gate_len = 16'd2;
    do_start();
    while (k_now < 10) cyc();
    start = 1'b1;
    cyc();
    start = 1'b0;
    while (k_now < 18) cyc();
    chk("stop pre trig", 32'(trig), 32'(1));
    chk("stop pre step", 32'(step), 32'(1));
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    chk("stop trig", 32'(trig), 32'(0));
    chk("stop busy", 32'(busy), 32'(0));
    chk("stop osc", 32'(osc_count), 32'(200));
    chk("stop done", 32'(done), 32'(0));
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (done || busy || trig) seen = 1'b1;
    end
    chk("stop stays idle", 32'(seen), 32'(0));
    chk("stop osc holds", 32'(osc_count), 32'(200));

    // start and stop together from IDLE: stop wins.
    start = 1'b1; stop = 1'b1;
    cyc();
    start = 1'b0; stop = 1'b0;
    chk("startstop busy", 32'(busy), 32'(0));
    chk("startstop trig", 32'(trig), 32'(0));
    repeat (5) cyc();
    chk("startstop busy later", 32'(busy), 32'(0));

`ifdef SEQ_LOOP_EN
    last_step = STEP_W'(1);
    do_start();
    add(0, 1, 100, 0, 1, 0);  add(16, 1, 200, 1, 1, 0);
    add(32, 1, 100, 0, 1, 0); add(48, 1, 200, 1, 1, 0);
    add(64, 1, 100, 0, 1, 0);
    run_vecs("loop");
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (done || !busy) seen = 1'b1;
    end
    chk("loop no done", 32'(seen), 32'(0));
    go_idle("loop");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
